// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: multi-cycle control unit for the Mini-MIPS core.
// Owns pc/ir and sequences FETCH -> DECODE -> EXEC -> MEM -> WB, with
// ready handshakes on both memories and a retired-instruction counter.
// Optional build macro MULTICYCLE_MUL_EN: mul holds EXEC for MUL_LAT
// cycles using an internal down-counter (absent when the macro is undefined).
module multicycle_ctrl #(
    parameter int          ADDR_W   = 15,
    parameter int unsigned RESET_PC = 0,
    parameter int          CNT_W    = 16,
    parameter int          MUL_LAT  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              imem_rdy,
    input  logic [31:0]       instr,
    input  logic              dmem_rdy,
    input  logic              alu_zero,
    input  logic              alu_neg,
    input  logic              alu_borrow,
    input  logic [ADDR_W-1:0] jr_addr,
    output logic [ADDR_W-1:0] pc,
    output logic [31:0]       ir,
    output logic [2:0]        state,
    output logic              imem_req,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic              rf_we,
    output logic              rf_we2,
    output logic              f_rf_we,
    output logic [1:0]        wb_sel,
    output logic [5:0]        alu_op,
    output logic              halted,
    output logic              illegal,
    output logic [CNT_W-1:0]  retired
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_HALT   = 3'd5
    } state_t;

    typedef enum logic [3:0] {
        C_ILL, C_RTYPE, C_ITYPE, C_LW, C_SW, C_BR,
        C_J, C_JR, C_JAL, C_HALT, C_MFC1, C_FP
    } iclass_t;

    localparam logic [1:0] WB_ALU  = 2'd0;
    localparam logic [1:0] WB_MEM  = 2'd1;
    localparam logic [1:0] WB_LINK = 2'd2;
    localparam logic [1:0] WB_FPU  = 2'd3;
    localparam logic [5:0] OP_MUL  = 6'b101101;

    if (MUL_LAT < 1) begin : g_bad_mul_lat
        $error("MUL_LAT must be at least 1");
    end
    if (ADDR_W < 1 || ADDR_W > 26) begin : g_bad_addr_w
        $error("ADDR_W must be in 1..26");
    end

    // Opcode class; lw/sw must be matched before the generic I-type pattern.
    function automatic iclass_t classify(input logic [5:0] op);
        casez (op)
            6'b001110: return C_LW;
            6'b001111: return C_SW;
            6'b00????: return C_ITYPE;
            6'b10????: return C_RTYPE;
            6'b010???: return C_BR;
            6'b011000: return C_J;
            6'b011001: return C_JR;
            6'b011010: return C_JAL;
            6'b011111: return C_HALT;
            6'b111000: return C_MFC1;
            6'b11????: return C_FP;
            default:   return C_ILL;
        endcase
    endfunction

    state_t  state_q;
    iclass_t ir_cls;
    logic    is_mul;
    logic    br_taken;
    logic    exec_done;

    assign state  = state_q;
    assign ir_cls = classify(ir[31:26]);
    assign is_mul = (ir[31:26] == OP_MUL);

    // Fetch request is a plain decode of the state so the very first
    // post-reset FETCH cycle already requests; reset masks it.
    assign imem_req = (state_q == S_FETCH) && !rst;

    // ALU op from the latched instruction: R/I ops carry the ALU code in the
    // low opcode nibble (mul remapped to 11); memory ops add, branches subtract.
    always_comb begin
        alu_op = 6'd0;
        case (ir_cls)
            C_LW, C_SW: alu_op = 6'd1;
            C_BR:       alu_op = 6'd2;
            C_RTYPE, C_ITYPE: begin
                if (ir[29:26] == 4'd13)
                    alu_op = 6'd11;
                else if (ir[29:26] >= 4'd1 && ir[29:26] <= 4'd10)
                    alu_op = {2'b00, ir[29:26]};
            end
            default: alu_op = 6'd0;
        endcase
    end

    // Branch condition from the rs-rt flags, selected by the low opcode bits.
    always_comb begin
        case (ir[28:26])
            3'd0:    br_taken = alu_zero;
            3'd1:    br_taken = !alu_zero;
            3'd2:    br_taken = !alu_neg && !alu_zero;
            3'd3:    br_taken = !alu_neg;
            3'd4:    br_taken = alu_neg;
            3'd5:    br_taken = alu_neg || alu_zero;
            3'd6:    br_taken = alu_borrow;
            default: br_taken = !alu_borrow && !alu_zero;
        endcase
    end

`ifdef MULTICYCLE_MUL_EN
    localparam int MC_W = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;
    logic [MC_W-1:0] mul_cnt;
    assign exec_done = !is_mul || (mul_cnt == '0);
`else
    assign exec_done = 1'b1;
`endif

    // Main sequencer: state, pc/ir, retired counter and registered strobes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_FETCH;
            pc       <= ADDR_W'(RESET_PC);
            ir       <= '0;
            retired  <= '0;
            dmem_req <= 1'b0;
            dmem_we  <= 1'b0;
            rf_we    <= 1'b0;
            rf_we2   <= 1'b0;
            f_rf_we  <= 1'b0;
            wb_sel   <= WB_ALU;
            halted   <= 1'b0;
            illegal  <= 1'b0;
`ifdef MULTICYCLE_MUL_EN
            mul_cnt  <= '0;
`endif
        end else begin
            // write strobes and illegal are single-cycle pulses
            rf_we   <= 1'b0;
            rf_we2  <= 1'b0;
            f_rf_we <= 1'b0;
            wb_sel  <= WB_ALU;
            illegal <= 1'b0;
            case (state_q)
                S_FETCH: begin
                    if (imem_rdy) begin
                        ir      <= instr;
                        pc      <= pc + 1'b1;
                        illegal <= (classify(instr[31:26]) == C_ILL);
                        state_q <= S_DECODE;
                    end
                end
                S_DECODE: begin
                    case (ir_cls)
                        C_ILL: begin
                            retired <= retired + 1'b1;
                            state_q <= S_FETCH;
                        end
                        C_HALT: begin
                            retired <= retired + 1'b1;
                            halted  <= 1'b1;
                            state_q <= S_HALT;
                        end
                        default: begin
`ifdef MULTICYCLE_MUL_EN
                            mul_cnt <= MC_W'(MUL_LAT - 1);
`endif
                            state_q <= S_EXEC;
                        end
                    endcase
                end
                S_EXEC: begin
                    if (exec_done) begin
                        case (ir_cls)
                            C_LW: begin
                                dmem_req <= 1'b1;
                                state_q  <= S_MEM;
                            end
                            C_SW: begin
                                dmem_req <= 1'b1;
                                dmem_we  <= 1'b1;
                                state_q  <= S_MEM;
                            end
                            C_BR: begin
                                if (br_taken) pc <= ir[ADDR_W-1:0];
                                retired <= retired + 1'b1;
                                state_q <= S_FETCH;
                            end
                            C_J: begin
                                pc      <= ir[ADDR_W-1:0];
                                retired <= retired + 1'b1;
                                state_q <= S_FETCH;
                            end
                            C_JR: begin
                                pc      <= jr_addr;
                                retired <= retired + 1'b1;
                                state_q <= S_FETCH;
                            end
                            C_JAL: begin
                                // link value is the pc shown during this cycle
                                pc      <= ir[ADDR_W-1:0];
                                rf_we   <= 1'b1;
                                wb_sel  <= WB_LINK;
                                state_q <= S_WB;
                            end
                            C_MFC1: begin
                                rf_we   <= 1'b1;
                                wb_sel  <= WB_FPU;
                                state_q <= S_WB;
                            end
                            C_FP: begin
                                f_rf_we <= 1'b1;
                                state_q <= S_WB;
                            end
                            default: begin
                                rf_we   <= 1'b1;
                                rf_we2  <= is_mul;
                                state_q <= S_WB;
                            end
                        endcase
                    end
`ifdef MULTICYCLE_MUL_EN
                    else begin
                        mul_cnt <= mul_cnt - 1'b1;
                    end
`endif
                end
                S_MEM: begin
                    if (dmem_rdy) begin
                        dmem_req <= 1'b0;
                        dmem_we  <= 1'b0;
                        if (ir_cls == C_SW) begin
                            retired <= retired + 1'b1;
                            state_q <= S_FETCH;
                        end else begin
                            rf_we   <= 1'b1;
                            wb_sel  <= WB_MEM;
                            state_q <= S_WB;
                        end
                    end
                end
                S_WB: begin
                    retired <= retired + 1'b1;
                    state_q <= S_FETCH;
                end
                S_HALT: state_q <= S_HALT;
                default: state_q <= S_FETCH;
            endcase
        end
    end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Bench for multicycle_ctrl: an instruction-level model expands each
// instruction into its expected per-cycle outputs; a negedge process checks
// the DUT against them, and literal checks pin the model.
module tb_multicycle_ctrl;
    localparam int          ADDR_W   = 15;
    localparam int unsigned RESET_PC = 5;
    localparam int          CNT_W    = 16;
    localparam int          MUL_LAT  = 4;
`ifdef MULTICYCLE_MUL_EN
    localparam int MUL_EXEC = MUL_LAT;
`else
    localparam int MUL_EXEC = 1;
`endif

    localparam logic [5:0] OP_ADD = 6'b100001, OP_SUB = 6'b100010, OP_XOR = 6'b100110,
                           OP_MUL = 6'b101101, OP_ADDI = 6'b000001,
                           OP_LW = 6'b001110, OP_SW = 6'b001111,
                           OP_BEQ = 6'b010000, OP_BNE = 6'b010001, OP_BGT = 6'b010010,
                           OP_BGE = 6'b010011, OP_BLT = 6'b010100, OP_BLE = 6'b010101,
                           OP_BLTU = 6'b010110, OP_BGTU = 6'b010111,
                           OP_J = 6'b011000, OP_JR = 6'b011001, OP_JAL = 6'b011010,
                           OP_HALT = 6'b011111, OP_MFC1 = 6'b111000, OP_MTC1 = 6'b111001,
                           OP_FADD = 6'b110001, OP_BAD = 6'b011011;

    localparam int K_ILL = 0, K_RT = 1, K_IT = 2, K_LW = 3, K_SW = 4, K_BR = 5,
                   K_J = 6, K_JR = 7, K_JAL = 8, K_HALT = 9, K_MFC1 = 10, K_FP = 11;

    // strobe vector: {imem_req,dmem_req,dmem_we,rf_we,rf_we2,f_rf_we,wb_sel[1:0],halted,illegal}
    localparam logic [9:0] S_IREQ = 10'b1000000000, S_DREQ = 10'b0100000000,
                           S_DWE  = 10'b0010000000, S_WE   = 10'b0001000000,
                           S_WE2  = 10'b0000100000, S_FWE  = 10'b0000010000,
                           S_HLT  = 10'b0000000010, S_ILL  = 10'b0000000001;

    localparam logic [2:0] ST_F = 3'd0, ST_D = 3'd1, ST_E = 3'd2, ST_M = 3'd3,
                           ST_W = 3'd4, ST_H = 3'd5;

    logic              clk, rst, imem_rdy, dmem_rdy, alu_zero, alu_neg, alu_borrow;
    logic [31:0]       instr;
    logic [ADDR_W-1:0] jr_addr, pc;
    logic [31:0]       ir;
    logic [2:0]        state;
    logic              imem_req, dmem_req, dmem_we, rf_we, rf_we2, f_rf_we, halted, illegal;
    logic [1:0]        wb_sel;
    logic [5:0]        alu_op;
    logic [CNT_W-1:0]  retired;

    multicycle_ctrl #(.ADDR_W(ADDR_W), .RESET_PC(RESET_PC), .CNT_W(CNT_W), .MUL_LAT(MUL_LAT)) dut (
        .clk(clk), .rst(rst), .imem_rdy(imem_rdy), .instr(instr), .dmem_rdy(dmem_rdy),
        .alu_zero(alu_zero), .alu_neg(alu_neg), .alu_borrow(alu_borrow), .jr_addr(jr_addr),
        .pc(pc), .ir(ir), .state(state), .imem_req(imem_req), .dmem_req(dmem_req),
        .dmem_we(dmem_we), .rf_we(rf_we), .rf_we2(rf_we2), .f_rf_we(f_rf_we),
        .wb_sel(wb_sel), .alu_op(alu_op), .halted(halted), .illegal(illegal), .retired(retired)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  st;
        logic [14:0] pc;
        logic [31:0] ir;
        logic [9:0]  strb;
        logic [15:0] ret;
        logic [5:0]  aop;
        bit          aop_v;
    } exp_t;

    exp_t        exp_q[$];
    int          n_cmp = 0, n_err = 0;
    logic [14:0] m_pc;
    logic [31:0] m_ir;
    logic [15:0] m_ret;

    // observers of the DUT, owned by the compare process
    int icyc = 0, we_cnt = 0, wb_at = 0, we2_cnt = 0, req_cnt = 0, dwe_cnt = 0;
    int exec_cnt = 0, ill_cnt = 0;
    logic [1:0]  wsel_at = 2'd0;
    logic [5:0]  aop_at = 6'd0;
    logic [14:0] pc_at_exec = 15'd0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic int m_class(input logic [5:0] op);
        casez (op)
            6'b001110: return K_LW;
            6'b001111: return K_SW;
            6'b00????: return K_IT;
            6'b10????: return K_RT;
            6'b0100??, 6'b0101??: return K_BR;
            6'b011000: return K_J;
            6'b011001: return K_JR;
            6'b011010: return K_JAL;
            6'b011111: return K_HALT;
            6'b111000: return K_MFC1;
            6'b11????: return K_FP;
            default:   return K_ILL;
        endcase
    endfunction

    function automatic logic [5:0] m_alu(input logic [5:0] op);
        case (op)
            OP_ADD, OP_ADDI, OP_LW, OP_SW: return 6'd1;
            OP_SUB: return 6'd2;
            OP_XOR: return 6'd6;
            OP_MUL: return 6'd11;
            OP_BEQ, OP_BNE, OP_BGT, OP_BGE, OP_BLT, OP_BLE, OP_BLTU, OP_BGTU: return 6'd2;
            default: return 6'd0;
        endcase
    endfunction

    function automatic logic m_taken(input logic [5:0] op, input logic z, input logic n, input logic b);
        case (op)
            OP_BEQ:  return z;
            OP_BNE:  return !z;
            OP_BGT:  return !n && !z;
            OP_BGE:  return !n;
            OP_BLT:  return n;
            OP_BLE:  return n || z;
            OP_BLTU: return b;
            OP_BGTU: return !b && !z;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [31:0] ins(input logic [5:0] op, input logic [25:0] t);
        return {op, t};
    endfunction

    // queue the expected outputs for the current cycle, then advance one cycle
    task automatic cyc(input logic [2:0] st, input logic [9:0] strb, input logic [5:0] aop, input bit aop_v);
        exp_t e;
        e.st = st; e.pc = m_pc; e.ir = m_ir; e.strb = strb; e.ret = m_ret;
        e.aop = aop; e.aop_v = aop_v;
        exp_q.push_back(e);
        @(posedge clk); #1;
    endtask

    task automatic run_instr(input logic [31:0] iword, input int iw, input int dw,
                             input logic z, input logic n, input logic b,
                             input logic [14:0] jra, input int abort);
        logic [5:0] op;
        logic [5:0] aop;
        logic [9:0] ws;
        int         kc;
        int         nex;
        op  = iword[31:26];
        kc  = m_class(op);
        aop = m_alu(op);
        dmem_rdy = 1'b1;
        for (int k = 0; k <= iw; k++) begin
            imem_rdy = (k == iw);
            instr    = (k == iw) ? iword : 32'hDEAD_BEEF;
            cyc(ST_F, S_IREQ, 6'd0, 1'b0);
        end
        imem_rdy = 1'b1;
        instr    = 32'hFFFF_FFFF;
        m_ir = iword;
        m_pc = m_pc + 15'd1;
        if (kc == K_ILL) begin
            cyc(ST_D, S_ILL, 6'd0, 1'b0);
            m_ret++;
            return;
        end
        cyc(ST_D, 10'd0, aop, 1'b1);
        if (kc == K_HALT) begin
            m_ret++;
            return;
        end
        alu_zero = z; alu_neg = n; alu_borrow = b; jr_addr = jra;
        nex = (op == OP_MUL) ? MUL_EXEC : 1;
        for (int k = 0; k < nex; k++) cyc(ST_E, 10'd0, aop, 1'b1);
        alu_zero = 1'b0; alu_neg = 1'b0; alu_borrow = 1'b0; jr_addr = 15'h5A5A;
        if (kc == K_BR && m_taken(op, z, n, b)) m_pc = iword[14:0];
        if (kc == K_J || kc == K_JAL) m_pc = iword[14:0];
        if (kc == K_JR) m_pc = jra;
        if (kc == K_LW || kc == K_SW) begin
            for (int k = 0; k <= dw; k++) begin
                if (k == abort) return;
                dmem_rdy = (k == dw);
                cyc(ST_M, S_DREQ | ((kc == K_SW) ? S_DWE : 10'd0), aop, 1'b1);
            end
            dmem_rdy = 1'b1;
        end
        if (kc == K_SW || kc == K_BR || kc == K_J || kc == K_JR) begin
            m_ret++;
            return;
        end
        case (kc)
            K_RT:    ws = S_WE | ((op == OP_MUL) ? S_WE2 : 10'd0);
            K_LW:    ws = S_WE | 10'b0000000100;
            K_JAL:   ws = S_WE | 10'b0000001000;
            K_MFC1:  ws = S_WE | 10'b0000001100;
            K_FP:    ws = S_FWE;
            default: ws = S_WE;
        endcase
        cyc(ST_W, ws, aop, 1'b1);
        m_ret++;
    endtask

    task automatic run1(input logic [31:0] iword);
        run_instr(iword, 0, 0, 1'b0, 1'b0, 1'b0, 15'd0, -1);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        m_pc = 15'(RESET_PC); m_ir = 32'd0; m_ret = 16'd0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_state", state, 3'd0);
        chk("rst_pc", pc, 15'd5);
        chk("rst_ir", ir, 32'd0);
        chk("rst_retired", retired, 16'd0);
        chk("rst_strobes", {imem_req, dmem_req, dmem_we, rf_we, rf_we2, f_rf_we, wb_sel, halted, illegal}, 10'd0);
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    // compare process: model expectations plus DUT observers
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            chk("state", state, e.st);
            chk("pc", pc, e.pc);
            chk("ir", ir, e.ir);
            chk("strobes", {imem_req, dmem_req, dmem_we, rf_we, rf_we2, f_rf_we, wb_sel, halted, illegal}, e.strb);
            chk("retired", retired, e.ret);
            if (e.aop_v) chk("alu_op", alu_op, e.aop);
        end
        icyc <= icyc + 1;
        if (dmem_req) req_cnt <= req_cnt + 1;
        if (dmem_we) dwe_cnt <= dwe_cnt + 1;
        if (rf_we) begin
            we_cnt  <= we_cnt + 1;
            wb_at   <= icyc + 1;
            wsel_at <= wb_sel;
            aop_at  <= alu_op;
        end
        if (rf_we && rf_we2) we2_cnt <= we2_cnt + 1;
        if (state == 3'd2) begin
            exec_cnt   <= exec_cnt + 1;
            pc_at_exec <= pc;
        end
        if (illegal) ill_cnt <= ill_cnt + 1;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int s, c0, c1, c2;
        rst = 1'b1; imem_rdy = 1'b0; instr = 32'd0; dmem_rdy = 1'b0;
        alu_zero = 1'b0; alu_neg = 1'b0; alu_borrow = 1'b0; jr_addr = 15'd0;
        do_reset();

        // add from RESET_PC
        s = icyc;
        run1(32'h8400_0000);
        chk("add_pc", pc, 15'd6);
        chk("add_retired", retired, 16'd1);
        chk("add_wb_cycle", wb_at - s, 4);
        chk("add_wb_sel", wsel_at, 2'd0);
        chk("add_alu_op", aop_at, 6'd1);

        // lw with 3 data wait states
        s = icyc; c0 = req_cnt; c1 = dwe_cnt;
        run_instr(ins(OP_LW, 26'd0), 0, 3, 1'b0, 1'b0, 1'b0, 15'd0, -1);
        chk("lw_req_cycles", req_cnt - c0, 4);
        chk("lw_no_dmem_we", dwe_cnt - c1, 0);
        chk("lw_wb_cycle", wb_at - s, 8);
        chk("lw_wb_sel", wsel_at, 2'd1);

        // sw with fetch wait states, then beq taken / not taken
        run_instr(ins(OP_SW, 26'd0), 2, 1, 1'b0, 1'b0, 1'b0, 15'd0, -1);
        c0 = we_cnt;
        run_instr(ins(OP_BEQ, 26'h123), 0, 0, 1'b1, 1'b0, 1'b0, 15'd0, -1);
        chk("beq_taken_pc", pc, 15'h123);
        run_instr(ins(OP_BEQ, 26'h456), 0, 0, 1'b0, 1'b0, 1'b0, 15'd0, -1);
        chk("beq_not_taken_pc", pc, 15'h124);
        chk("beq_no_write", we_cnt - c0, 0);

        // j to 10, then jal to 0x40
        run1(ins(OP_J, 26'd10));
        chk("j_pc", pc, 15'd10);
        run1(ins(OP_JAL, 26'h40));
        chk("jal_link_pc", pc_at_exec, 15'd11);
        chk("jal_pc", pc, 15'h40);
        chk("jal_wb_sel", wsel_at, 2'd2);

        // remaining branch conditions
        run_instr(ins(OP_BNE, 26'h50), 0, 0, 1'b1, 1'b0, 1'b0, 15'd0, -1);
        run_instr(ins(OP_BGT, 26'h60), 0, 0, 1'b0, 1'b0, 1'b0, 15'd0, -1);
        run_instr(ins(OP_BGE, 26'h70), 0, 0, 1'b0, 1'b1, 1'b0, 15'd0, -1);
        run_instr(ins(OP_BLT, 26'h80), 0, 0, 1'b0, 1'b1, 1'b0, 15'd0, -1);
        run_instr(ins(OP_BLE, 26'h90), 0, 0, 1'b1, 1'b0, 1'b0, 15'd0, -1);
        run_instr(ins(OP_BLTU, 26'hA0), 0, 0, 1'b0, 1'b0, 1'b1, 15'd0, -1);
        run_instr(ins(OP_BGTU, 26'hB0), 0, 0, 1'b1, 1'b0, 1'b0, 15'd0, -1);
        run_instr(ins(OP_BGTU, 26'hC0), 0, 0, 1'b0, 1'b0, 1'b0, 15'd0, -1);
        chk("bgtu_taken_pc", pc, 15'hC0);
        run_instr(ins(OP_JR, 26'd0), 1, 0, 1'b0, 1'b0, 1'b0, 15'h0777, -1);
        chk("jr_pc", pc, 15'h0777);

        // mul, FP and integer mix
        c0 = exec_cnt; c1 = we2_cnt;
        run1(ins(OP_MUL, 26'd0));
        chk("mul_exec_cycles", exec_cnt - c0, MUL_EXEC);
        chk("mul_we2_with_we", we2_cnt - c1, 1);
        run1(ins(OP_FADD, 26'd0));
        run1(ins(OP_MFC1, 26'd0));
        chk("mfc1_wb_sel", wsel_at, 2'd3);
        run1(ins(OP_MTC1, 26'd0));
        run1(ins(OP_ADDI, 26'd0));
        run_instr(ins(OP_XOR, 26'd0), 1, 0, 1'b0, 1'b0, 1'b0, 15'd0, -1);
        run1(ins(OP_SUB, 26'd0));

        // illegal opcode
        s = icyc; c2 = ill_cnt;
        run1(ins(OP_BAD, 26'd0));
        chk("illegal_pulses", ill_cnt - c2, 1);
        chk("illegal_cycles", icyc - s, 2);

        // pc wrap at 2^ADDR_W
        run1(ins(OP_J, 26'h7FFF));
        run1(32'h8400_0000);
        chk("pc_wrap", pc, 15'd0);

        // reset in the middle of an sw data wait
        run_instr(ins(OP_SW, 26'd0), 0, 50, 1'b0, 1'b0, 1'b0, 15'd0, 2);
        do_reset();
        c0 = dwe_cnt;
        run1(32'h8400_0000);
        chk("post_rst_pc", pc, 15'd6);
        chk("post_rst_no_dmem_we", dwe_cnt - c0, 0);

        // halt is sticky
        run1(ins(OP_HALT, 26'd0));
        for (int k = 0; k < 100; k++) cyc(ST_H, S_HLT, 6'd0, 1'b0);
        chk("halt_state", state, 3'd5);
        chk("halt_flag", halted, 1'b1);
        chk("halt_retired", retired, 16'd2);

        @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
